// File: rtl/booth_mul_sched_if.sv
// Bundle of the two request channels, the response channel and status for booth_mul_sched.
// Every channel uses valid/ready: a transfer happens on the rising edge where both are high;
// the source holds its payload while valid is high and ready is low.
interface booth_mul_sched_if #(
    parameter int WIDTH = 32
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [2*WIDTH-1:0]   rsp_result;
    logic                 busy;
    logic [1:0]           fsm_state;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, busy, fsm_state
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, busy, fsm_state
    );
endinterface

// File: rtl/booth_mul_sched.sv
// Iterative radix-4 Booth signed multiplier shared by two requesters through a
// round-robin grant; one Booth digit per cycle, response tagged with the requester id.
module booth_mul_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mul_sched_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;
    logic [SW-1:0]    step;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    a_sh;
    logic [WIDTH:0]   b_sh;

    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [PW-1:0]    term;
    logic [PW-1:0]    sum;

    always_comb begin
        grant_valid = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_id    = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
        sel_a       = grant_id ? bus.req1_a : bus.req0_a;
        sel_b       = grant_id ? bus.req1_b : bus.req0_b;
    end

    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid && grant_id;
    assign bus.fsm_state  = state;

    // a_sh already carries the 2k shift and the sign extension, so doubling and
    // negation act on the full product width and wrap modulo 2^PW.
    always_comb begin
        term = '0;
        case (b_sh[2:0])
            3'b001, 3'b010: term = a_sh;
            3'b011:         term = a_sh << 1;
            3'b100:         term = -(a_sh << 1);
            3'b101, 3'b110: term = -a_sh;
            default:        term = '0;
        endcase
        sum = acc + term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            step           <= '0;
            acc            <= '0;
            a_sh           <= '0;
            b_sh           <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        a_sh       <= {{WIDTH{sel_a[WIDTH-1]}}, sel_a};
                        b_sh       <= {sel_b, 1'b0};
                        acc        <= '0;
                        step       <= '0;
                        ptr        <= ~grant_id;
                        bus.rsp_id <= grant_id;
                        bus.busy   <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= sum;
                    a_sh <= a_sh << 2;
                    b_sh <= {2'b00, b_sh[WIDTH:2]};
                    step <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        bus.rsp_result <= sum;
                        bus.rsp_valid  <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE (not granting here) guarantees a gap cycle between jobs.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched: single jobs, extreme operands, contention,
// backpressure and reset mid-operation, with a response scoreboard.
module tb_booth_mul_sched;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    logic [2*W:0] exp_q[$];

    booth_mul_sched_if #(.WIDTH(W)) bus ();

    booth_mul_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // scoreboard: every accepted response is compared with the head of exp_q
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("rsp_id", {63'd0, bus.rsp_id}, {63'd0, e[2*W]});
                check("rsp_result", bus.rsp_result, e[2*W-1:0]);
            end
        end
    end

    // driver tasks
    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic send(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] expv);
        bit done;
        exp_q.push_back({port, expv});
        @(posedge clk); #1;
        if (port) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
        else      begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (port ? bus.req1_ready : bus.req0_ready) done = 1'b1;
        end
        if (!done) check("send_grant_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // observes n grants with both ports requesting; order must alternate from port 0
    task automatic watch_grants(input int n);
        int grants;
        int last_cyc;
        grants   = 0;
        last_cyc = 0;
        for (int t = 0; t < 400 && grants < n; t++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                check("grant_order", {63'd0, bus.req1_ready}, 64'(grants % 2));
                check("grant_onehot", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
                if (grants > 0) check("accept_interval", 64'(cyc - last_cyc), 64'd18);
                last_cyc = cyc;
                grants++;
            end
        end
        if (grants < n) check("grant_timeout", 64'(grants), 64'(n));
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        int   lat;
        bit   busy_ok;
        bit   hold_ok;
        logic [2*W-1:0] held_res;
        logic held_id;

        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid",  {63'd0, bus.rsp_valid}, 64'd0);
        check("reset_rsp_id",     {63'd0, bus.rsp_id}, 64'd0);
        check("reset_rsp_result", bus.rsp_result, 64'd0);
        check("reset_busy",       {63'd0, bus.busy}, 64'd0);
        check("reset_ready0",     {63'd0, bus.req0_ready}, 64'd0);
        check("reset_ready1",     {63'd0, bus.req1_ready}, 64'd0);
        check("reset_state",      {62'd0, bus.fsm_state}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single request: latency and busy throughout
        bus.rsp_ready = 1'b1;
        send(1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        lat = 0;
        busy_ok = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            busy_ok &= bus.busy;
            lat++;
        end
        check("latency", 64'(lat), 64'd16);
        check("busy_throughout", {63'd0, busy_ok & bus.busy}, 64'd1);
        @(negedge clk);
        check("idle_after_rsp", {63'd0, bus.rsp_valid | bus.busy}, 64'd0);
        wait_idle();

        // extreme and assorted operands
        send(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000); wait_idle();
        send(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000); wait_idle();
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF); wait_idle();
        send(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001); wait_idle();
        send(1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E); wait_idle();
        send(1'b1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000); wait_idle();
        send(1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780); wait_idle();
        send(1'b1, 32'h0000_0000, 32'h8765_4321, 64'h0000_0000_0000_0000); wait_idle();
        send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001); wait_idle();

        // contention from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 64'h0000_0000_0000_000F});
        exp_q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFEE});
        exp_q.push_back({1'b0, 64'h0000_0000_0000_000F});
        exp_q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFEE});
        bus.req0_a = 32'd3;          bus.req0_b = 32'd5;
        bus.req1_a = 32'hFFFF_FFFE;  bus.req1_b = 32'd9;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        watch_grants(4);
        wait_idle();

        // backpressure: DONE holds while rsp_ready is low
        bus.rsp_ready = 1'b0;
        send(1'b1, 32'hFFFF_FFF9, 32'd11, 64'hFFFF_FFFF_FFFF_FFB3);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        held_res = bus.rsp_result;
        held_id  = bus.rsp_id;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        hold_ok = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            hold_ok &= bus.rsp_valid && bus.busy && !bus.req0_ready && !bus.req1_ready;
            hold_ok &= (bus.rsp_result === held_res) && (bus.rsp_id === held_id);
        end
        check("bp_hold_stable", {63'd0, hold_ok}, 64'd1);
        check("bp_held_result", held_res, 64'hFFFF_FFFF_FFFF_FFB3);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        check("bp_release_state", {62'd0, bus.fsm_state}, 64'd0);
        check("bp_release_valid", {63'd0, bus.rsp_valid | bus.busy}, 64'd0);

        // reset at step 5 of a port-1 job
        bus.rsp_ready = 1'b1;
        send(1'b1, 32'd100, 32'd200, 64'd20000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid",  {63'd0, bus.rsp_valid}, 64'd0);
        check("midrst_rsp_id",     {63'd0, bus.rsp_id}, 64'd0);
        check("midrst_rsp_result", bus.rsp_result, 64'd0);
        check("midrst_busy",       {63'd0, bus.busy}, 64'd0);
        check("midrst_state",      {62'd0, bus.fsm_state}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 64'd6});
        exp_q.push_back({1'b1, 64'd20});
        bus.req0_a = 32'd2; bus.req0_b = 32'd3;
        bus.req1_a = 32'd4; bus.req1_b = 32'd5;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst_n = 1'b1;
        watch_grants(2);
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
